axi_lite_rd_xbar: RTL

Read-only AXI-lite interconnect between the core's load/fetch master and two read slaves: main memory (slave 0, default) and the CLINT timer (slave 1). Decodes each read address, forwards the AR beat to one slave, and returns that slave's R beat to the master. Handles one transaction at a time. Optionally answers unmapped addresses locally with DECERR.

---
 rtl/axi_lite_rd_xbar_pkg.sv | 29 ++
 rtl/axi_lite_rd_xbar_addr_decode.sv | 34 +++
 rtl/axi_lite_rd_xbar.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/axi_lite_rd_xbar_pkg.sv
// Shared definitions for the AXI-lite read crossbar and its address decoder.
// Optional feature macro used by the files importing this package: XBAR_DECERR_EN.
package axi_lite_rd_xbar_pkg;

    // AXI read response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Crossbar transaction FSM; ST_ERR is only reachable when DECERR is compiled in
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_RW   = 2'd2,
        ST_ERR  = 2'd3
    } xbar_state_t;

    // Slave select: memory is the default target
    typedef enum logic {
        SEL_MEM   = 1'b0,
        SEL_CLINT = 1'b1
    } xbar_sel_t;

    // Default address map
    localparam logic [31:0] DEF_CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] DEF_CLINT_MASK = 32'hFFFF_0000;
    localparam logic [31:0] DEF_MEM_BASE   = 32'h8000_0000;
    localparam logic [31:0] DEF_MEM_MASK   = 32'hF800_0000;

endpackage

// File: rtl/axi_lite_rd_xbar_addr_decode.sv
// Combinational address decoder (xbar_addr_decode), shared by the read and
// future write crossbars. With XBAR_DECERR_EN defined, addresses outside both
// the CLINT and memory regions are flagged unmapped; otherwise memory takes
// every non-CLINT address and o_unmapped is tied low.
module xbar_addr_decode
    import axi_lite_rd_xbar_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = DEF_CLINT_BASE,
    parameter logic [31:0] CLINT_MASK = DEF_CLINT_MASK,
    parameter logic [31:0] MEM_BASE   = DEF_MEM_BASE,
    parameter logic [31:0] MEM_MASK   = DEF_MEM_MASK
) (
    input  logic [31:0] i_addr,
    output logic        o_sel,      // 1 = CLINT, 0 = memory
    output logic        o_unmapped
);

    logic w_clint_hit;
    logic w_mem_hit;

    assign w_clint_hit = ((i_addr & CLINT_MASK) == CLINT_BASE);
    assign w_mem_hit   = ((i_addr & MEM_MASK) == MEM_BASE);
    assign o_sel       = w_clint_hit;

`ifdef XBAR_DECERR_EN
    assign o_unmapped = !w_clint_hit && !w_mem_hit;
`else
    // Memory region match is meaningless when memory is the catch-all slave
    logic w_unused_mem_hit;
    assign w_unused_mem_hit = w_mem_hit;
    assign o_unmapped       = 1'b0;
`endif

endmodule

// File: rtl/axi_lite_rd_xbar.sv
// Read-only AXI-lite crossbar: one master, memory (slave 0) and CLINT (slave 1).
// One transaction in flight. XBAR_DECERR_EN adds a local DECERR response for
// unmapped addresses.
//
// Handshake rule on every channel: a beat transfers on the rising edge where
// valid and ready are both high; valid never depends on ready, and the R path
// is a combinational pass-through from the selected slave while in ST_RW.
module axi_lite_rd_xbar
    import axi_lite_rd_xbar_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = DEF_CLINT_BASE,
    parameter logic [31:0] CLINT_MASK = DEF_CLINT_MASK,
    parameter logic [31:0] MEM_BASE   = DEF_MEM_BASE,
    parameter logic [31:0] MEM_MASK   = DEF_MEM_MASK
) (
    input  logic        clk,
    input  logic        rst_n,
    // master
    input  logic [31:0] m_araddr,
    input  logic        m_arvalid,
    output logic        m_arready,
    output logic [31:0] m_rdata,
    output logic [1:0]  m_rresp,
    output logic        m_rvalid,
    input  logic        m_rready,
    // slave 0: memory
    output logic [31:0] s0_araddr,
    output logic        s0_arvalid,
    input  logic        s0_arready,
    input  logic [31:0] s0_rdata,
    input  logic [1:0]  s0_rresp,
    input  logic        s0_rvalid,
    output logic        s0_rready,
    // slave 1: CLINT
    output logic [31:0] s1_araddr,
    output logic        s1_arvalid,
    input  logic        s1_arready,
    input  logic [31:0] s1_rdata,
    input  logic [1:0]  s1_rresp,
    input  logic        s1_rvalid,
    output logic        s1_rready,
    // FSM state for observation
    output logic [1:0]  o_dbg_state
);

    xbar_state_t r_state;
    xbar_state_t w_next;
    logic [31:0] r_addr;
    xbar_sel_t   r_sel;

    logic w_dec_sel;
    logic w_dec_unmapped;
    logic w_accept;
    logic w_sel_arready;

    xbar_addr_decode #(
        .CLINT_BASE (CLINT_BASE),
        .CLINT_MASK (CLINT_MASK),
        .MEM_BASE   (MEM_BASE),
        .MEM_MASK   (MEM_MASK)
    ) u_decode (
        .i_addr     (m_araddr),
        .o_sel      (w_dec_sel),
        .o_unmapped (w_dec_unmapped)
    );

`ifndef XBAR_DECERR_EN
    logic w_unused_unmapped;
    assign w_unused_unmapped = w_dec_unmapped;
`endif

    assign w_accept      = (r_state == ST_IDLE) && m_arvalid;
    assign w_sel_arready = (r_sel == SEL_CLINT) ? s1_arready : s0_arready;
    assign s0_araddr     = r_addr;
    assign s1_araddr     = r_addr;
    assign o_dbg_state   = r_state;

    // State register; reset drops every valid at once because all outputs decode r_state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture address and target on accept; held until the next accept so araddr stays stable through R
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= 32'h0;
            r_sel  <= SEL_MEM;
        end else if (w_accept) begin
            r_addr <= m_araddr;
            r_sel  <= xbar_sel_t'(w_dec_sel);
        end
    end

    // Next state and all handshake/data outputs; unselected slave and off-state rvalid are ignored
    always_comb begin
        w_next     = r_state;
        m_arready  = 1'b0;
        m_rvalid   = 1'b0;
        m_rdata    = 32'h0;
        m_rresp    = RESP_OKAY;
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;
        s0_rready  = 1'b0;
        s1_rready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                m_arready = 1'b1;
                if (m_arvalid) begin
`ifdef XBAR_DECERR_EN
                    w_next = w_dec_unmapped ? ST_ERR : ST_AR;
`else
                    w_next = ST_AR;
`endif
                end
            end
            ST_AR: begin
                s0_arvalid = (r_sel == SEL_MEM);
                s1_arvalid = (r_sel == SEL_CLINT);
                if (w_sel_arready) begin
                    w_next = ST_RW;
                end
            end
            ST_RW: begin
                if (r_sel == SEL_CLINT) begin
                    m_rvalid  = s1_rvalid;
                    m_rdata   = s1_rdata;
                    m_rresp   = s1_rresp;
                    s1_rready = m_rready;
                end else begin
                    m_rvalid  = s0_rvalid;
                    m_rdata   = s0_rdata;
                    m_rresp   = s0_rresp;
                    s0_rready = m_rready;
                end
                if (m_rvalid && m_rready) begin
                    w_next = ST_IDLE;
                end
            end
`ifdef XBAR_DECERR_EN
            ST_ERR: begin
                m_rvalid = 1'b1;
                m_rdata  = 32'h0;
                m_rresp  = RESP_DECERR;
                if (m_rready) begin
                    w_next = ST_IDLE;
                end
            end
`endif
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule
